load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Core-side initiator for the byte-wide data port of the unified memory. It accepts one load or store per request (byte or 16-bit word) and splits word accesses into two little-endian byte transactions. It drives the mem_req/mem_done handshake with a timeout, then returns the assembled, extended load data, or a store completion, to the core.

Parameters:
TIMEOUT, 15, cycles to wait for mem_done in a WAIT state before aborting with error (1..255)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1=store, 0=load
req_word  input  1  1=16-bit access, 0=byte access
req_signed  input  1  sign-extend byte loads (ignored for words/stores)
req_addr  input  16  byte address
req_wdata  input  16  store data (byte store uses [7:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  16  load result (0 for stores and errors)
resp_error  output  1  qualifies resp_valid; memory timeout
mem_addr  output  16  byte address to memory data port
mem_wdata  output  8  byte to write
mem_write  output  1  write enable for this transaction
mem_req  output  1  one-cycle access request pulse
mem_done  input  1  memory completion, asserted cycle after mem_req sampled
mem_rdata  input  8  read byte, valid while mem_done=1 with mem_addr held

Behaviour:
- Reset: state IDLE; req_ready=1 after reset released; resp_valid=0, resp_rdata=0, resp_error=0, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch write/word/signed/addr/wdata and go to ISSUE0. mem_done in IDLE is ignored.
- ISSUE0: mem_req=1 for exactly one cycle; mem_addr=addr, mem_wdata=wdata[7:0], mem_write=write. Next state: WAIT0.
- WAIT0: mem_req=0; mem_addr, mem_wdata and mem_write held stable. On mem_done: capture mem_rdata as low byte, then go to ISSUE1 if word, else RESP.
- ISSUE1/WAIT1: same pattern with mem_addr=addr+1 (16-bit wrap: 0xFFFF -> 0x0000) and mem_wdata=wdata[15:8]. On mem_done, capture the high byte and go to RESP.
- Timeout: counter clears on entry to each WAIT state and increments each WAIT cycle without mem_done. When the count reaches TIMEOUT, go to RESP with the error flag set. mem_done arriving in the same cycle as the limit counts as success.
- RESP: resp_valid=1 for one cycle.
  - Load OK: word -> {hi, lo}; byte signed -> {8{lo[7]}, lo}; byte unsigned -> {8'h00, lo}.
  - Store or error: resp_rdata=0.
  - resp_error reflects the timeout flag.
  - Next state: IDLE.
- Outputs are registered. resp_valid, resp_error and mem_req are 0 outside their states. resp_rdata holds its value until the next RESP.
- Latency (accept edge = cycle T): byte access completes with resp_valid at T+3; word at T+5, given mem_done one cycle after each mem_req.
- There is no response backpressure. req_ready=0 in every state except IDLE, including RESP, so back-to-back requests are spaced by one IDLE cycle.
- Misaligned word accesses are legal and use the same two-transaction sequence.
- Reset mid-operation returns to IDLE immediately with no response emitted and mem_req dropped. A late mem_done after reset is ignored.

Test Plan:
- Byte load unsigned at 0x0011, memory returns 0x9C -> one mem_req with mem_addr=0x0011, mem_write=0; resp_valid at T+3, resp_rdata=0x009C, resp_error=0.
- Byte load signed same data -> resp_rdata=0xFF9C; req_ready low from T+1 to T+3, high at T+4.
- Word store 0xBEEF at 0x0020 -> two mem_req pulses two cycles apart: (0x0020, 0xEF, write=1) then (0x0021, 0xBE, write=1); resp_valid at T+5, resp_rdata=0.
- Word load at 0xFFFF, bytes 0x34 then 0x12 -> second access to 0x0000; resp_rdata=0x1234.
- No mem_done with TIMEOUT=15 -> resp_valid with resp_error=1 and resp_rdata=0 after 15 WAIT0 cycles; the second byte of a word is never issued; next request accepted normally.
- Reset asserted in WAIT1 of a word load -> next cycle in IDLE with all outputs 0 and no resp_valid; a stray mem_done is ignored; a following byte load completes at T+3.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the byte-wide memory data port.
// Accepts one byte or 16-bit load/store per request and splits word accesses
// into two little-endian byte transactions (addr, then addr+1 with 16-bit wrap).
// Each transaction is a one-cycle mem_req pulse answered by mem_done; a WAIT
// state that sees no mem_done for TIMEOUT cycles aborts with resp_error.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   req_valid/req_ready     - core request handshake (ready only in IDLE)
//   req_write/word/signed   - store/load, word/byte, sign-extend byte loads
//   req_addr, req_wdata     - byte address, store data
//   resp_valid/error/rdata  - one-cycle completion pulse, timeout flag, load data
//   mem_addr/wdata/write    - memory transaction address, byte, write enable
//   mem_req                 - one-cycle access request pulse
//   mem_done, mem_rdata     - memory completion and read byte
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  output logic        mem_req,
  input  logic        mem_done,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CntW = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      lo_q, lo_d, hi_q, hi_d;
  logic            err_q, err_d;
  logic            wr_q, wr_d, word_q, word_d, sgn_q, sgn_d;
  logic [15:0]     addr_q, addr_d, wdata_q, wdata_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [15:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_error_q, resp_error_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_req_q, mem_req_d;

  logic            limit_hit;

  // The current WAIT cycle is the TIMEOUT-th without mem_done.
  assign limit_hit = (cnt_q + CntW'(1)) == CntW'(TIMEOUT);

  // State and datapath register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, request latch, byte capture and timeout counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    wr_d    = wr_q;
    word_d  = word_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          word_d  = req_word;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          state_d = ISSUE0;
        end
      end
      ISSUE0: begin
        cnt_d   = '0;
        state_d = WAIT0;
      end
      WAIT0: begin
        // mem_done wins over a simultaneous timeout
        if (mem_done) begin
          lo_d    = mem_rdata;
          state_d = word_q ? ISSUE1 : RESP;
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ISSUE1: begin
        cnt_d   = '0;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_done) begin
          hi_d    = mem_rdata;
          state_d = RESP;
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, decoded from the state being entered so every
  // output is a flop that is valid for the whole cycle of its state.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = mem_write_q;
    case (state_d)
      ISSUE0: begin
        mem_req_d   = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d[7:0];
        mem_write_d = wr_d;
      end
      ISSUE1: begin
        mem_req_d   = 1'b1;
        mem_addr_d  = addr_q + 16'd1;
        mem_wdata_d = wdata_q[15:8];
        mem_write_d = wr_q;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_error_d = err_d;
        if (err_d || wr_q) begin
          resp_rdata_d = '0;
        end else if (word_q) begin
          resp_rdata_d = {hi_d, lo_d};
        end else if (sgn_q) begin
          resp_rdata_d = {{8{lo_d[7]}}, lo_d};
        end else begin
          resp_rdata_d = {8'h00, lo_d};
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized bench for load_store_unit with a byte memory
// model and a transaction-level reference (expected byte accesses, latency
// and response computed from the request fields).
module tb_load_store_unit;

  localparam int unsigned TO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_word, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_write, mem_req, mem_done;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_req(mem_req), .mem_done(mem_done),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte memory: unwritten locations read back a fixed address hash.
  logic [7:0] mem [logic [15:0]];

  function automatic logic [7:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'(a[7:0] ^ a[15:8] ^ 8'hA5);
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        wr;
    int          c;
  } txn_t;

  txn_t log_q[$];
  logic drop_done = 1'b0;
  logic stray = 1'b0;
  logic pend = 1'b0;

  // Memory responder: mem_done one cycle after mem_req is sampled.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      mem_done = (pend && !drop_done) || stray;
      if (pend) mem_rdata = rd(mem_addr);
      else if (stray) mem_rdata = 8'($urandom);
      pend  = 1'b0;
      stray = 1'b0;
      @(negedge clock);
      if (mem_req) begin
        log_q.push_back('{addr: mem_addr, wd: mem_wdata, wr: mem_write, c: cyc});
        if (mem_write) mem[mem_addr] = mem_wdata;
        pend = 1'b1;
      end
    end
  end

  // One request end to end; entered and left at #1 after a rising edge.
  task automatic do_req(input logic wr, input logic wd, input logic sg,
                        input logic [15:0] a, input logic [15:0] d, input logic drop);
    logic [7:0]  b0, b1;
    logic [15:0] a1, exp_rd;
    int          acc, lat, exp_lat, n_exp;
    bit          seen;
    a1 = a + 16'd1;
    b0 = rd(a);
    b1 = rd(a1);
    if (drop || wr)   exp_rd = 16'h0000;
    else if (wd)      exp_rd = {b1, b0};
    else if (sg)      exp_rd = {{8{b0[7]}}, b0};
    else              exp_rd = {8'h00, b0};
    exp_lat = drop ? int'(2 + TO) : (wd ? 5 : 3);
    n_exp   = drop ? 1 : (wd ? 2 : 1);

    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clock);
      #1;
    end
    check_val("ready_before_req", 32'(req_ready), 32'd1);
    drop_done = drop;
    log_q.delete();
    req_valid = 1'b1; req_write = wr; req_word = wd; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    acc = cyc - 1;
    check_val("ready_low_T1", 32'(req_ready), 32'd0);

    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (resp_valid) begin
        seen = 1'b1;
        lat  = cyc - acc;
        check_val("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
        check_val("resp_error", 32'(resp_error), 32'(drop));
        check_val("ready_low_resp", 32'(req_ready), 32'd0);
      end else begin
        @(posedge clock);
        #1;
      end
    end
    check_val("resp_seen", 32'(seen), 32'd1);
    check_val("latency", 32'(lat), 32'(exp_lat));

    @(posedge clock);
    #1;
    check_val("resp_pulse_end", 32'(resp_valid), 32'd0);
    check_val("ready_after", 32'(req_ready), 32'd1);
    check_val("resp_hold", 32'(resp_rdata), 32'(exp_rd));

    check_val("txn_count", 32'(log_q.size()), 32'(n_exp));
    if (log_q.size() >= 1) begin
      check_val("txn0_addr", 32'(log_q[0].addr), 32'(a));
      check_val("txn0_wr", 32'(log_q[0].wr), 32'(wr));
      check_val("txn0_cyc", 32'(log_q[0].c - acc), 32'd1);
      if (wr) check_val("txn0_wd", 32'(log_q[0].wd), 32'(d[7:0]));
    end
    if (log_q.size() >= 2 && n_exp == 2) begin
      check_val("txn1_addr", 32'(log_q[1].addr), 32'(a1));
      check_val("txn1_wr", 32'(log_q[1].wr), 32'(wr));
      check_val("txn1_cyc", 32'(log_q[1].c - acc), 32'd3);
      if (wr) check_val("txn1_wd", 32'(log_q[1].wd), 32'(d[15:8]));
    end
    drop_done = 1'b0;
  endtask

  initial begin
    int acc;
    bit bad;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check_val("rst_resp_error", 32'(resp_error), 32'd0);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_mem_write", 32'(mem_write), 32'd0);

    mem[16'h0011] = 8'h9C;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);
    do_req(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0);
    check_val("store_lo", 32'(rd(16'h0020)), 32'h00EF);
    check_val("store_hi", 32'(rd(16'h0021)), 32'h00BE);
    do_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1);
    do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);

    // Reset during WAIT1 of a word load, then a stray mem_done in IDLE.
    log_q.delete();
    req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0100; req_wdata = 16'h0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    acc = cyc - 1;
    drop_done = 1'b1;
    while (cyc - acc < 4) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    stray = 1'b1;
    check_val("mid_rst_ready", 32'(req_ready), 32'd1);
    check_val("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check_val("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("mid_rst_mem_write", 32'(mem_write), 32'd0);
    check_val("mid_rst_rdata", 32'(resp_rdata), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid || mem_req || !req_ready) bad = 1'b1;
    end
    check_val("stray_done_ignored", 32'(bad), 32'd0);
    drop_done = 1'b0;
    do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      do_req(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom),
             $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
